// File: rtl/multi_chan_fifo_pkg.sv
// Shared types and helpers for the multi-channel FIFO: the per-channel
// status struct and the pointer-width function.
package multi_chan_fifo_pkg;

  // Widest usage field carried in the status struct (LOG_DEPTH up to 15).
  localparam int USAGE_W = 16;

  typedef struct packed {
    logic [USAGE_W-1:0] usage;
    logic               empty;
    logic               full;
    logic               almost_full;
  } chan_status_t;

  // One extra MSB beyond the address bits distinguishes full from empty.
  function automatic int ptr_width(input int log_depth);
    return log_depth + 1;
  endfunction

endpackage

// File: rtl/multi_chan_fifo_ptr.sv
// Per-channel pointer pair with flush handling and status decode.
// push_i/pop_i arrive already qualified by the top-level handshake.
module multi_chan_fifo_ptr
  import multi_chan_fifo_pkg::*;
#(
  parameter int LOG_DEPTH = 3,
  parameter int AF_THRESH = 2**LOG_DEPTH - 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  output logic [LOG_DEPTH:0]   wptr_o,
  output logic [LOG_DEPTH:0]   rptr_o,
  output chan_status_t         status_o
);

  localparam int PW = ptr_width(LOG_DEPTH);

  logic [PW-1:0] usage;

  // Pointer registers: reset and flush both return the channel to empty.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i || flush_i) begin
      wptr_o <= '0;
      rptr_o <= '0;
    end else begin
      if (push_i) wptr_o <= wptr_o + 1'b1;
      if (pop_i)  rptr_o <= rptr_o + 1'b1;
    end
  end

  // Status decode from the pointer difference (wraps modulo 2**PW).
  always_comb begin
    usage                = wptr_o - rptr_o;
    status_o.usage       = USAGE_W'(usage);
    status_o.empty       = (wptr_o == rptr_o);
    status_o.full        = ((wptr_o ^ rptr_o) == {1'b1, {LOG_DEPTH{1'b0}}});
    status_o.almost_full = (usage >= PW'(AF_THRESH));
  end

endmodule

// File: rtl/multi_chan_fifo.sv
// Multi-channel FIFO over one shared storage array addressed {chan, ptr}.
// First-word fall-through read port; per-channel flush.
// Optional sticky overflow/underflow flags: define MULTI_CHAN_FIFO_ERR_EN.
module multi_chan_fifo
  import multi_chan_fifo_pkg::*;
#(
  parameter int  WIDTH     = 1,
  parameter type T         = logic [WIDTH-1:0],
  parameter int  LOG_DEPTH = 3,
  parameter int  N_CHAN    = 4,
  parameter int  AF_THRESH = 2**LOG_DEPTH - 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            src_valid_i,
  input  logic [$clog2(N_CHAN)-1:0]       src_chan_i,
  input  T                                src_data_i,
  output logic                            src_ready_o,
  input  logic [$clog2(N_CHAN)-1:0]       dst_chan_i,
  input  logic                            dst_ready_i,
  output logic                            dst_valid_o,
  output T                                dst_data_o,
  input  logic [N_CHAN-1:0]               flush_i,
  output logic [N_CHAN-1:0][LOG_DEPTH:0]  usage_o,
  output logic [N_CHAN-1:0]               empty_o,
  output logic [N_CHAN-1:0]               full_o,
`ifdef MULTI_CHAN_FIFO_ERR_EN
  output logic [N_CHAN-1:0]               overflow_o,
  output logic [N_CHAN-1:0]               underflow_o,
`endif
  output logic [N_CHAN-1:0]               almost_full_o
);

  localparam int CW    = $clog2(N_CHAN);
  localparam int PW    = ptr_width(LOG_DEPTH);
  localparam int DEPTH = 2**LOG_DEPTH;
  localparam int AW    = CW + LOG_DEPTH;

  T               mem [N_CHAN*DEPTH];
  logic [PW-1:0]  wptr [N_CHAN];
  logic [PW-1:0]  rptr [N_CHAN];
  chan_status_t   st   [N_CHAN];
  logic [N_CHAN-1:0] push_sel;
  logic [N_CHAN-1:0] pop_sel;
  logic [AW-1:0]  wr_addr;
  logic [AW-1:0]  rd_addr;
  logic           push;
  logic           pop;

  for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
    multi_chan_fifo_ptr #(
      .LOG_DEPTH (LOG_DEPTH),
      .AF_THRESH (AF_THRESH)
    ) u_ptr (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push_i   (push_sel[c]),
      .pop_i    (pop_sel[c]),
      .flush_i  (flush_i[c]),
      .wptr_o   (wptr[c]),
      .rptr_o   (rptr[c]),
      .status_o (st[c])
    );

    assign usage_o[c]       = st[c].usage[LOG_DEPTH:0];
    assign empty_o[c]       = st[c].empty;
    assign full_o[c]        = st[c].full;
    assign almost_full_o[c] = st[c].almost_full;
  end

  // Handshakes: a full channel never accepts, even if popped this cycle.
  assign src_ready_o = !full_o[src_chan_i] && !flush_i[src_chan_i];
  assign dst_valid_o = !empty_o[dst_chan_i] && !flush_i[dst_chan_i];
  assign push        = src_valid_i && src_ready_o;
  assign pop         = dst_ready_i && dst_valid_o;
  assign wr_addr     = {src_chan_i, wptr[src_chan_i][LOG_DEPTH-1:0]};
  assign rd_addr     = {dst_chan_i, rptr[dst_chan_i][LOG_DEPTH-1:0]};

  // Steer the qualified push/pop to the addressed channel.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    push_sel = '0;
    pop_sel  = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      push_sel[c] = push && (src_chan_i == CW'(c));
      pop_sel[c]  = pop  && (dst_chan_i == CW'(c));
    end
  end

  // Storage write port.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is deliberately not reset; pointers alone define which
    // words are live, so stale contents are never observable.
    if (push) mem[wr_addr] <= src_data_i;
  end

  // Fall-through read: head word of the selected channel, zero when idle.
  always_comb begin
    dst_data_o = '0;
    if (dst_valid_o) dst_data_o = mem[rd_addr];
  end

`ifdef MULTI_CHAN_FIFO_ERR_EN
  // Sticky error flags; cleared only by reset or the channel's flush.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < N_CHAN; c++) begin
      if (rst_i || flush_i[c]) begin
        overflow_o[c]  <= 1'b0;
        underflow_o[c] <= 1'b0;
      end else begin
        if (src_valid_i && (src_chan_i == CW'(c)) && full_o[c])
          overflow_o[c] <= 1'b1;
        if (dst_ready_i && (dst_chan_i == CW'(c)) && empty_o[c])
          underflow_o[c] <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multi_chan_fifo.sv
// Directed bench for multi_chan_fifo: 4 channels x 8 words, 8-bit payload,
// almost-full threshold 6. Inputs change and outputs are sampled 1 ns after
// the rising edge.
module tb_multi_chan_fifo;

  logic            clk;
  logic            rst_i;
  logic            src_valid_i;
  logic [1:0]      src_chan_i;
  logic [7:0]      src_data_i;
  logic            src_ready_o;
  logic [1:0]      dst_chan_i;
  logic            dst_ready_i;
  logic            dst_valid_o;
  logic [7:0]      dst_data_o;
  logic [3:0]      flush_i;
  logic [3:0][3:0] usage_o;
  logic [3:0]      empty_o;
  logic [3:0]      full_o;
  logic [3:0]      almost_full_o;
`ifdef MULTI_CHAN_FIFO_ERR_EN
  logic [3:0]      overflow_o;
  logic [3:0]      underflow_o;
`endif

  int passed = 0;
  int total  = 0;

  multi_chan_fifo #(
    .WIDTH     (8),
    .LOG_DEPTH (3),
    .N_CHAN    (4),
    .AF_THRESH (6)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .src_valid_i   (src_valid_i),
    .src_chan_i    (src_chan_i),
    .src_data_i    (src_data_i),
    .src_ready_o   (src_ready_o),
    .dst_chan_i    (dst_chan_i),
    .dst_ready_i   (dst_ready_i),
    .dst_valid_o   (dst_valid_o),
    .dst_data_o    (dst_data_o),
    .flush_i       (flush_i),
    .usage_o       (usage_o),
    .empty_o       (empty_o),
    .full_o        (full_o),
`ifdef MULTI_CHAN_FIFO_ERR_EN
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o),
`endif
    .almost_full_o (almost_full_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    rst_i       = 1'b1;
    src_valid_i = 1'b0;
    src_chan_i  = 2'd0;
    src_data_i  = 8'h00;
    dst_chan_i  = 2'd0;
    dst_ready_i = 1'b0;
    flush_i     = 4'b0000;
    tick();
    tick();
    rst_i = 1'b0;
    #1;

    // Reset state
    chk("rst_src_ready", src_ready_o, 1);
    chk("rst_dst_valid", dst_valid_o, 0);
    chk("rst_dst_data", dst_data_o, 0);
    chk("rst_usage", usage_o, 0);
    chk("rst_empty", empty_o, 4'hF);
    chk("rst_full", full_o, 0);
    chk("rst_af", almost_full_o, 0);
`ifdef MULTI_CHAN_FIFO_ERR_EN
    chk("rst_ovf", overflow_o, 0);
    chk("rst_udf", underflow_o, 0);
`endif

    // Push 0xA5 to ch2: not visible before the edge, visible after it
    src_valid_i = 1'b1; src_chan_i = 2'd2; src_data_i = 8'hA5; dst_chan_i = 2'd2;
    #1;
    chk("no_bypass_valid", dst_valid_o, 0);
    tick();
    src_valid_i = 1'b0;
    #1;
    chk("a5_valid", dst_valid_o, 1);
    chk("a5_data", dst_data_o, 8'hA5);
    chk("a5_usage2", usage_o[2], 1);
    dst_ready_i = 1'b1;
    tick();
    dst_ready_i = 1'b0;
    #1;
    chk("a5_popped_empty", empty_o[2], 1);
    chk("idle_data_zero", dst_data_o, 0);

    // Fill ch1 with 8 words
    for (int i = 0; i < 8; i++) begin
      src_valid_i = 1'b1; src_chan_i = 2'd1; src_data_i = 8'h10 + 8'(i);
      tick();
    end
    src_valid_i = 1'b0;
    #1;
    chk("ch1_full", full_o[1], 1);
    chk("ch1_usage8", usage_o[1], 8);
    chk("ch1_ready_low", src_ready_o, 0);
    src_chan_i = 2'd0;
    #1;
    chk("ch0_ready_high", src_ready_o, 1);

    // Full ch1: a same-cycle pop does not make room for the push
    src_valid_i = 1'b1; src_chan_i = 2'd1; src_data_i = 8'hEE;
    dst_chan_i = 2'd1; dst_ready_i = 1'b1;
    #1;
    chk("full_pop_ready", src_ready_o, 0);
    chk("full_pop_head", dst_data_o, 8'h10);
    tick();
    src_valid_i = 1'b0; dst_ready_i = 1'b0;
    #1;
    chk("full_pop_usage7", usage_o[1], 7);
    chk("full_pop_next", dst_data_o, 8'h11);

    // ch3 at usage 4: 20 push/pop pairs, wrapping the pointers
    for (int i = 0; i < 4; i++) begin
      src_valid_i = 1'b1; src_chan_i = 2'd3; src_data_i = 8'h30 + 8'(i);
      tick();
    end
    dst_chan_i = 2'd3;
    for (int i = 0; i < 20; i++) begin
      src_valid_i = 1'b1; src_chan_i = 2'd3; src_data_i = 8'h34 + 8'(i);
      dst_ready_i = 1'b1;
      #1;
      chk($sformatf("pp_data%0d", i), dst_data_o, 8'h30 + 8'(i));
      chk($sformatf("pp_usage%0d", i), usage_o[3], 4);
      tick();
    end
    src_valid_i = 1'b0; dst_ready_i = 1'b0;
    #1;
    chk("pp_usage_end", usage_o[3], 4);
    chk("pp_head_end", dst_data_o, 8'h44);

    // Almost-full on ch0 at threshold 6
    for (int i = 0; i < 5; i++) begin
      src_valid_i = 1'b1; src_chan_i = 2'd0; src_data_i = 8'h50 + 8'(i);
      tick();
    end
    src_valid_i = 1'b0;
    #1;
    chk("af_usage5", usage_o[0], 5);
    chk("af_at5", almost_full_o[0], 0);
    src_valid_i = 1'b1; src_data_i = 8'h55;
    tick();
    src_valid_i = 1'b0;
    #1;
    chk("af_usage6", usage_o[0], 6);
    chk("af_vector", almost_full_o, 4'b0011);
    dst_chan_i = 2'd0; dst_ready_i = 1'b1;
    tick();
    dst_ready_i = 1'b0;
    #1;
    chk("af_back5", almost_full_o, 4'b0010);

    // Flush ch0 with a simultaneous push at usage 5
    flush_i = 4'b0001;
    src_valid_i = 1'b1; src_chan_i = 2'd0; src_data_i = 8'h99;
    #1;
    chk("flush_ready_low", src_ready_o, 0);
    chk("flush_valid_low", dst_valid_o, 0);
    tick();
    flush_i = 4'b0000; src_valid_i = 1'b0;
    #1;
    chk("flush_usage0", usage_o[0], 0);
    chk("flush_empty0", empty_o[0], 1);
    chk("flush_ch1_kept", usage_o[1], 7);
    chk("flush_dst_valid", dst_valid_o, 0);

    // Independent push (ch2) and pop (ch1) in one cycle
    src_valid_i = 1'b1; src_chan_i = 2'd2; src_data_i = 8'h77;
    dst_chan_i = 2'd1; dst_ready_i = 1'b1;
    tick();
    src_valid_i = 1'b0; dst_ready_i = 1'b0;
    #1;
    chk("xchan_usage2", usage_o[2], 1);
    chk("xchan_usage1", usage_o[1], 6);
    chk("xchan_head1", dst_data_o, 8'h12);
    dst_chan_i = 2'd2;
    #1;
    chk("xchan_head2", dst_data_o, 8'h77);

`ifdef MULTI_CHAN_FIFO_ERR_EN
    // Overflow on ch1 was recorded by the refused push; flush clears it
    chk("ovf_sticky", overflow_o, 4'b0010);
    chk("udf_none", underflow_o, 0);
    flush_i = 4'b0010;
    tick();
    flush_i = 4'b0000;
    #1;
    chk("ovf_flushed", overflow_o, 0);
    dst_chan_i = 2'd1; dst_ready_i = 1'b1;
    tick();
    dst_ready_i = 1'b0;
    #1;
    chk("udf_set", underflow_o, 4'b0010);
    tick();
    chk("udf_hold", underflow_o, 4'b0010);
`endif

    // Reset mid-operation discards all data
    dst_chan_i = 2'd3;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk("mid_rst_usage", usage_o, 0);
    chk("mid_rst_empty", empty_o, 4'hF);
    chk("mid_rst_full", full_o, 0);
    chk("mid_rst_af", almost_full_o, 0);
    chk("mid_rst_valid", dst_valid_o, 0);
    chk("mid_rst_data", dst_data_o, 0);
    chk("mid_rst_ready", src_ready_o, 1);
`ifdef MULTI_CHAN_FIFO_ERR_EN
    chk("mid_rst_udf", underflow_o, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
